// File: rtl/timer_pkg.sv
// Shared definitions for the capture timer: edge-select encodings, default widths
// and the edge-select decode helper.
package timer_pkg;

    localparam int unsigned CNT_W_DEF      = 16;
    localparam int unsigned PSC_W_DEF      = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_sel_e;

    // True when an edge of the given polarity is enabled by the select code.
    function automatic logic edge_enabled(input logic [1:0] sel, input logic rise);
        if (sel == EDGE_BOTH) return 1'b1;
        if (rise)             return sel == EDGE_RISE;
        return sel == EDGE_FALL;
    endfunction

endpackage

// File: rtl/timer_capture_if.sv
// Capture event bus: one-cycle strobe carrying the timestamp and edge polarity.
interface timer_capture_if
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic             valid;
    logic             rise;
    logic [CNT_W-1:0] data;

    modport master (output valid, output rise, output data);
    modport slave  (input  valid, input  rise, input  data);
endinterface

// File: rtl/timer_capture_sync.sv
// Two-flop pin synchroniser, optional 3-cycle stability filter (TIMER_CAPTURE_FILTER_EN)
// and edge detector; emits a registered capture event stamped with the detection-cycle count.
module timer_capture_sync
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [1:0]       edge_sel_i,
    input  logic             cap_i,
    input  logic [CNT_W-1:0] cnt_i,
    timer_capture_if.master  evt
);

    logic sync1;
    logic sync2;
    logic level;
    logic level_d;

`ifdef TIMER_CAPTURE_FILTER_EN
    logic hist1;
    logic hist2;
    logic filt;

    // Accept a new level only once three consecutive synchronised samples agree.
    assign level = ((sync2 == hist1) && (hist1 == hist2)) ? sync2 : filt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hist1 <= 1'b0;
            hist2 <= 1'b0;
            filt  <= 1'b0;
        end else begin
            hist1 <= sync2;
            hist2 <= hist1;
            filt  <= level;
        end
    end
`else
    assign level = sync2;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            level_d   <= 1'b0;
            evt.valid <= 1'b0;
            evt.rise  <= 1'b0;
            evt.data  <= '0;
        end else begin
            sync1     <= cap_i;
            sync2     <= sync1;
            level_d   <= level;
            evt.valid <= en_i && (level != level_d) && edge_enabled(edge_sel_i, level);
            if (level != level_d) begin
                evt.rise <= level;
                evt.data <= cnt_i;
            end
        end
    end

endmodule

// File: rtl/timer_capture.sv
// Prescaled free-running timestamp counter with pin-edge capture into a small FIFO.
// Optional input glitch filter is enabled by defining TIMER_CAPTURE_FILTER_EN.
module timer_capture
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned PSC_W      = PSC_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [PSC_W-1:0] psc_i,
    input  logic [1:0]       edge_sel_i,
    input  logic             cap_i,
    output logic [CNT_W-1:0] cap_data_o,
    output logic             cap_edge_o,
    output logic             cap_valid_o,
    input  logic             cap_ready_i,
    output logic             ovf_o,
    input  logic             ovf_clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

    logic [PSC_W-1:0]  psc_cnt;
    logic [CNT_W-1:0]  mem_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_rise;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [AW:0]       count_nxt;
    logic              pop;
    logic              push;
    logic              overrun;

    timer_capture_if #(.CNT_W(CNT_W)) evt ();

    timer_capture_sync #(.CNT_W(CNT_W)) u_sync (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (en_i),
        .edge_sel_i (edge_sel_i),
        .cap_i      (cap_i),
        .cnt_i      (cnt_o),
        .evt        (evt)
    );

    // Prescaler: >= rather than == so a lowered psc_i takes effect at once without a long wrap.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            psc_cnt <= '0;
            cnt_o   <= '0;
        end else if (en_i) begin
            if (psc_cnt >= psc_i) begin
                psc_cnt <= '0;
                cnt_o   <= cnt_o + CNT_W'(1);
            end else begin
                psc_cnt <= psc_cnt + PSC_W'(1);
            end
        end
    end

    always_comb begin
        pop       = cap_valid_o && cap_ready_i;
        overrun   = evt.valid && (count == DEPTH_CNT) && !pop;
        push      = evt.valid && !overrun;
        count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
    end

    assign cap_data_o = mem_data[rd_ptr];
    assign cap_edge_o = mem_rise[rd_ptr];

    // Capture FIFO; a push into a full FIFO is dropped unless a pop frees a slot that cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_data[i] <= '0;
            mem_rise    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            cap_valid_o <= 1'b0;
            ovf_o       <= 1'b0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= evt.data;
                mem_rise[wr_ptr] <= evt.rise;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count       <= count_nxt;
            cap_valid_o <= (count_nxt != '0);
            if (overrun)        ovf_o <= 1'b1;
            else if (ovf_clr_i) ovf_o <= 1'b0;
        end
    end

endmodule
